// File: rtl/up_mem_dma.sv
// Block copy / block fill initiator for the 8-bit processor memory port.
// Each copied byte takes a read cycle (RD, which waits on mem_re) followed by a write cycle (WR).
module up_mem_dma (
    input  logic       clk,
    input  logic       nRst,
    input  logic       start,
    input  logic       mode,
    input  logic [7:0] src,
    input  logic [7:0] dst,
    input  logic [7:0] len,
    input  logic [7:0] fill,
    output logic       busy,
    output logic       done,
    output logic [7:0] sum,
    output logic [7:0] mem_address,
    output logic [7:0] mem_in,
    output logic       mem_we,
    input  logic [7:0] mem_out,
    input  logic       mem_re
);

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {IDLE, RD, WR, FILL, DONE} state_t;

    state_t              state, state_nx;
    logic [DATA_W-1:0]   src_r, src_nx;
    logic [DATA_W-1:0]   dst_r, dst_nx;
    logic [DATA_W-1:0]   len_r, len_nx;
    logic [DATA_W-1:0]   fill_r, fill_nx;
    logic [DATA_W-1:0]   i_r, i_nx;
    logic [DATA_W-1:0]   data_r, data_nx;
    logic [DATA_W-1:0]   sum_r, sum_nx;
    logic [DATA_W-1:0]   i_inc;

    // Address offsets and the checksum both wrap modulo 256.
    function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        logic [DATA_W:0] full;
        full = {1'b0, a} + {1'b0, b};
        return full[DATA_W-1:0];
    endfunction

    assign i_inc = add_wrap(i_r, 8'd1);
    assign sum   = sum_r;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state  <= IDLE;
            src_r  <= '0;
            dst_r  <= '0;
            len_r  <= '0;
            fill_r <= '0;
            i_r    <= '0;
            data_r <= '0;
            sum_r  <= '0;
        end else begin
            state  <= state_nx;
            src_r  <= src_nx;
            dst_r  <= dst_nx;
            len_r  <= len_nx;
            fill_r <= fill_nx;
            i_r    <= i_nx;
            data_r <= data_nx;
            sum_r  <= sum_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        src_nx      = src_r;
        dst_nx      = dst_r;
        len_nx      = len_r;
        fill_nx     = fill_r;
        i_nx        = i_r;
        data_nx     = data_r;
        sum_nx      = sum_r;
        busy        = 1'b1;
        done        = 1'b0;
        mem_address = '0;
        mem_in      = '0;
        mem_we      = 1'b0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    src_nx  = src;
                    dst_nx  = dst;
                    len_nx  = len;
                    fill_nx = fill;
                    i_nx    = '0;
                    sum_nx  = '0;
                    // The chosen mode lives on in the state encoding (RD vs FILL).
                    if (len == 8'd0)
                        state_nx = DONE;
                    else if (mode)
                        state_nx = FILL;
                    else
                        state_nx = RD;
                end
            end
            RD: begin
                mem_address = add_wrap(src_r, i_r);
                if (mem_re) begin
                    data_nx  = mem_out;
                    state_nx = WR;
                end
            end
            WR: begin
                mem_address = add_wrap(dst_r, i_r);
                mem_in      = data_r;
                mem_we      = 1'b1;
                sum_nx      = add_wrap(sum_r, data_r);
                i_nx        = i_inc;
                state_nx    = (i_inc == len_r) ? DONE : RD;
            end
            FILL: begin
                mem_address = add_wrap(dst_r, i_r);
                mem_in      = fill_r;
                mem_we      = 1'b1;
                sum_nx      = add_wrap(sum_r, fill_r);
                i_nx        = i_inc;
                state_nx    = (i_inc == len_r) ? DONE : FILL;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_up_mem_dma.sv
// Directed bench for up_mem_dma: a behavioural 256-byte memory plus scenario tasks.
module tb_up_mem_dma;

    logic       clk;
    logic       nRst;
    logic       start;
    logic       mode;
    logic [7:0] src;
    logic [7:0] dst;
    logic [7:0] len;
    logic [7:0] fill;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic [7:0] mem_address;
    logic [7:0] mem_in;
    logic       mem_we;
    logic [7:0] mem_out;
    logic       mem_re;

    logic [7:0] mem [0:255];

    int checks;
    int errors;

    up_mem_dma dut (
        .clk(clk), .nRst(nRst), .start(start), .mode(mode), .src(src), .dst(dst),
        .len(len), .fill(fill), .busy(busy), .done(done), .sum(sum),
        .mem_address(mem_address), .mem_in(mem_in), .mem_we(mem_we),
        .mem_out(mem_out), .mem_re(mem_re)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_out = mem[mem_address];

    always @(posedge clk) begin
        if (mem_we)
            mem[mem_address] <= mem_in;
    end

    task automatic clear_mem();
        for (int a = 0; a < 256; a++)
            mem[a] = 8'h00;
    endtask

    // Issues one command (start sampled at edge E0) and counts cycles after E0 until done.
    task automatic run_cmd(input logic m, input logic [7:0] s, input logic [7:0] d,
                           input logic [7:0] l, input logic [7:0] f, input int stall,
                           output int dcyc, output int wecnt);
        dcyc  = -1;
        wecnt = 0;
        @(negedge clk);
        mode = m; src = s; dst = d; len = l; fill = f; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk);
            mem_re = (k <= stall) ? 1'b0 : 1'b1;
            if (mem_we) wecnt++;
            if (done) begin
                dcyc = k;
                break;
            end
        end
        mem_re = 1'b1;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %h want 0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum got %h want 00", sum); end
        checks++; if (mem_address !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", mem_address); end
        checks++; if (mem_in !== 8'h00) begin errors++; $display("FAIL reset_in got %h want 00", mem_in); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %h want 0", mem_we); end
        nRst = 1'b1;
    endtask

    task automatic test_copy();
        int dc, wc;
        clear_mem();
        mem[8'h80] = 8'h12; mem[8'h81] = 8'h34; mem[8'h82] = 8'h56; mem[8'h83] = 8'h78;
        run_cmd(1'b0, 8'h80, 8'h40, 8'd4, 8'h00, 0, dc, wc);
        checks++; if (dc !== 9) begin errors++; $display("FAIL copy_done_cycle got %0d want 9", dc); end
        checks++; if (wc !== 4) begin errors++; $display("FAIL copy_we_count got %0d want 4", wc); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL copy_busy_after got %h want 0", busy); end
        checks++; if (mem[8'h40] !== 8'h12) begin errors++; $display("FAIL copy_m40 got %h want 12", mem[8'h40]); end
        checks++; if (mem[8'h41] !== 8'h34) begin errors++; $display("FAIL copy_m41 got %h want 34", mem[8'h41]); end
        checks++; if (mem[8'h42] !== 8'h56) begin errors++; $display("FAIL copy_m42 got %h want 56", mem[8'h42]); end
        checks++; if (mem[8'h43] !== 8'h78) begin errors++; $display("FAIL copy_m43 got %h want 78", mem[8'h43]); end
        checks++; if (sum !== 8'h14) begin errors++; $display("FAIL copy_sum got %h want 14", sum); end
    endtask

    task automatic test_fill_wrap();
        int dc, wc;
        clear_mem();
        run_cmd(1'b1, 8'h00, 8'hFE, 8'd4, 8'hA5, 0, dc, wc);
        checks++; if (dc !== 5) begin errors++; $display("FAIL fill_done_cycle got %0d want 5", dc); end
        checks++; if (wc !== 4) begin errors++; $display("FAIL fill_we_count got %0d want 4", wc); end
        @(negedge clk);
        checks++; if (mem[8'hFE] !== 8'hA5) begin errors++; $display("FAIL fill_mFE got %h want a5", mem[8'hFE]); end
        checks++; if (mem[8'hFF] !== 8'hA5) begin errors++; $display("FAIL fill_mFF got %h want a5", mem[8'hFF]); end
        checks++; if (mem[8'h00] !== 8'hA5) begin errors++; $display("FAIL fill_m00 got %h want a5", mem[8'h00]); end
        checks++; if (mem[8'h01] !== 8'hA5) begin errors++; $display("FAIL fill_m01 got %h want a5", mem[8'h01]); end
        checks++; if (mem[8'h02] !== 8'h00) begin errors++; $display("FAIL fill_m02 got %h want 00", mem[8'h02]); end
        checks++; if (sum !== 8'h94) begin errors++; $display("FAIL fill_sum got %h want 94", sum); end
    endtask

    task automatic test_wait_states();
        int dc, wc;
        clear_mem();
        mem[8'h20] = 8'h9A; mem[8'h21] = 8'hBC;
        run_cmd(1'b0, 8'h20, 8'h60, 8'd2, 8'h00, 3, dc, wc);
        checks++; if (dc !== 8) begin errors++; $display("FAIL wait_done_cycle got %0d want 8", dc); end
        @(negedge clk);
        checks++; if (mem[8'h60] !== 8'h9A) begin errors++; $display("FAIL wait_m60 got %h want 9a", mem[8'h60]); end
        checks++; if (mem[8'h61] !== 8'hBC) begin errors++; $display("FAIL wait_m61 got %h want bc", mem[8'h61]); end
        checks++; if (sum !== 8'h56) begin errors++; $display("FAIL wait_sum got %h want 56", sum); end
    endtask

    task automatic test_len0_busy_start();
        int dc, wc;
        clear_mem();
        run_cmd(1'b1, 8'h00, 8'h30, 8'd0, 8'h77, 0, dc, wc);
        checks++; if (dc !== 1) begin errors++; $display("FAIL len0_done_cycle got %0d want 1", dc); end
        checks++; if (wc !== 0) begin errors++; $display("FAIL len0_we_count got %0d want 0", wc); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL len0_sum got %h want 00", sum); end
        checks++; if (mem[8'h30] !== 8'h00) begin errors++; $display("FAIL len0_m30 got %h want 00", mem[8'h30]); end
        // Fill of 3 bytes; start re-pulsed with different parameters during cycles 1-2.
        dc = -1;
        @(negedge clk);
        mode = 1'b1; dst = 8'h50; len = 8'd3; fill = 8'h11; start = 1'b1;
        @(posedge clk);
        #1 dst = 8'h70; len = 8'd5; fill = 8'hEE;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 3) start = 1'b0;
            if (done) begin
                dc = k;
                break;
            end
        end
        start = 1'b0;
        checks++; if (dc !== 4) begin errors++; $display("FAIL busystart_done_cycle got %0d want 4", dc); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busystart_idle got %h want 0", busy); end
        checks++; if (sum !== 8'h33) begin errors++; $display("FAIL busystart_sum got %h want 33", sum); end
        checks++; if (mem[8'h52] !== 8'h11) begin errors++; $display("FAIL busystart_m52 got %h want 11", mem[8'h52]); end
        checks++; if (mem[8'h70] !== 8'h00) begin errors++; $display("FAIL busystart_m70 got %h want 00", mem[8'h70]); end
    endtask

    task automatic test_reset_mid();
        int dc, wc;
        clear_mem();
        for (int a = 0; a < 8; a++)
            mem[8'hA0 + a] = 8'(a + 1);
        @(negedge clk);
        mode = 1'b0; src = 8'hA0; dst = 8'hC0; len = 8'd8; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_address !== 8'hC2) begin
            errors++; $display("FAIL rstmid_third_wr got we=%h addr=%h want we=1 addr=c2", mem_we, mem_address);
        end
        nRst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %h want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %h want 0", done); end
        checks++; if (sum !== 8'h00) begin errors++; $display("FAIL rstmid_sum got %h want 00", sum); end
        checks++; if (mem_address !== 8'h00) begin errors++; $display("FAIL rstmid_addr got %h want 00", mem_address); end
        checks++; if (mem_in !== 8'h00) begin errors++; $display("FAIL rstmid_in got %h want 00", mem_in); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rstmid_we got %h want 0", mem_we); end
        @(posedge clk);
        @(negedge clk);
        nRst = 1'b1;
        checks++; if (mem[8'hC0] !== 8'h01) begin errors++; $display("FAIL rstmid_mC0 got %h want 01", mem[8'hC0]); end
        checks++; if (mem[8'hC1] !== 8'h02) begin errors++; $display("FAIL rstmid_mC1 got %h want 02", mem[8'hC1]); end
        checks++; if (mem[8'hC2] !== 8'h00) begin errors++; $display("FAIL rstmid_mC2 got %h want 00", mem[8'hC2]); end
        run_cmd(1'b0, 8'hA7, 8'hD0, 8'd1, 8'h00, 0, dc, wc);
        checks++; if (dc !== 3) begin errors++; $display("FAIL rstmid_new_done got %0d want 3", dc); end
        @(negedge clk);
        checks++; if (mem[8'hD0] !== 8'h08) begin errors++; $display("FAIL rstmid_new_mD0 got %h want 08", mem[8'hD0]); end
        checks++; if (sum !== 8'h08) begin errors++; $display("FAIL rstmid_new_sum got %h want 08", sum); end
    endtask

    task automatic test_overlap();
        int dc, wc;
        clear_mem();
        mem[8'h10] = 8'hCC;
        run_cmd(1'b0, 8'h10, 8'h11, 8'd3, 8'h00, 0, dc, wc);
        @(negedge clk);
        checks++; if (mem[8'h11] !== 8'hCC) begin errors++; $display("FAIL overlap_m11 got %h want cc", mem[8'h11]); end
        checks++; if (mem[8'h12] !== 8'hCC) begin errors++; $display("FAIL overlap_m12 got %h want cc", mem[8'h12]); end
        checks++; if (mem[8'h13] !== 8'hCC) begin errors++; $display("FAIL overlap_m13 got %h want cc", mem[8'h13]); end
        checks++; if (sum !== 8'h64) begin errors++; $display("FAIL overlap_sum got %h want 64", sum); end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        clear_mem();
        d1 = -1; d2 = -1;
        @(negedge clk);
        mode = 1'b1; dst = 8'h90; len = 8'd1; fill = 8'h05; start = 1'b1;
        @(posedge clk);
        #1 dst = 8'h91; fill = 8'h06;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 4) start = 1'b0;
            if (done) begin
                if (d1 < 0) d1 = k;
                else begin
                    d2 = k;
                    break;
                end
            end
        end
        start = 1'b0;
        checks++; if (d1 !== 2) begin errors++; $display("FAIL b2b_first_done got %0d want 2", d1); end
        checks++; if (d2 !== 5) begin errors++; $display("FAIL b2b_second_done got %0d want 5", d2); end
        @(negedge clk);
        checks++; if (mem[8'h90] !== 8'h05) begin errors++; $display("FAIL b2b_m90 got %h want 05", mem[8'h90]); end
        checks++; if (mem[8'h91] !== 8'h06) begin errors++; $display("FAIL b2b_m91 got %h want 06", mem[8'h91]); end
        checks++; if (sum !== 8'h06) begin errors++; $display("FAIL b2b_sum got %h want 06", sum); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nRst   = 1'b0;
        start  = 1'b0;
        mode   = 1'b0;
        src    = 8'h00;
        dst    = 8'h00;
        len    = 8'h00;
        fill   = 8'h00;
        mem_re = 1'b1;
        clear_mem();
        test_reset();
        test_copy();
        test_fill_wrap();
        test_wait_states();
        test_len0_busy_start();
        test_reset_mid();
        test_overlap();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/up_mem_dma.md
# up_mem_dma

Memory-side initiator for the microprocessor's 8-bit memory. It drives the memory's write data, address and write enable, reads back the memory's combinational read data, and performs block copy or block fill operations of up to 255 bytes on command. It sits beside the core as a second master on the memory port; bus arbitration is external to this block.

## Interface
- No parameters; data and address widths are fixed at 8 bits.
- clk  input  1  system clock, rising edge
- nRst  input  1  asynchronous active-low reset
- start  input  1  command strobe, sampled only in IDLE
- mode  input  1  0 = copy, 1 = fill; sampled with start
- src  input  8  copy source base address; sampled with start
- dst  input  8  destination base address; sampled with start
- len  input  8  byte count; 0 means no transfer; sampled with start
- fill  input  8  fill value; sampled with start
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- sum  output  8  mod-256 sum of all bytes written by the last command
- mem_address  output  8  memory address
- mem_in  output  8  write data to memory
- mem_we  output  1  memory write enable
- mem_out  input  8  combinational read data from memory
- mem_re  input  1  read-data-valid qualifier from memory

## Operation
- States: IDLE, RD, WR, FILL, DONE.
- IDLE
  - When start=1, register mode, src, dst, len and fill; clear the counter i and sum.
  - Next state: DONE if len=0, otherwise RD if mode=0, otherwise FILL.
  - start is ignored in every state other than IDLE.
- RD
  - mem_address=src+i, mem_we=0.
  - If mem_re=1, capture mem_out into the data register and go to WR. Otherwise stay in RD (wait state).
- WR
  - mem_address=dst+i, mem_in=data register, mem_we=1.
  - sum+=data, i+=1.
  - Go to DONE if i+1=len, otherwise go to RD.
- FILL
  - mem_address=dst+i, mem_in=fill, mem_we=1.
  - sum+=fill, i+=1.
  - Go to DONE if i+1=len, otherwise stay in FILL.
  - mem_re is ignored in FILL.
- DONE
  - done=1 for this cycle only; return to IDLE.
- Address arithmetic is mod 256. src+i and dst+i wrap from 0xFF to 0x00 with no error.
- Copy runs in ascending address order. Overlapping regions are copied in that order without correction: with dst=src+1, the byte at src is replicated across the region.
- In IDLE, RD and DONE: mem_we=0. In IDLE and DONE: mem_address=0x00 and mem_in=0x00. In RD: mem_in=0x00.
- sum holds its value from done until the next accepted start.

## Timing
- Reset values: state=IDLE, busy=0, done=0, sum=0x00, mem_address=0x00, mem_in=0x00, mem_we=0, internal registers 0.
- Reset asserted mid-operation forces IDLE immediately. Bytes already written stay written; the command is not resumed.
- Let start be sampled at rising edge E0, with mem_re held high throughout:
  - Copy: RD occupies cycles 1, 3, 5, …; WR occupies cycles 2, 4, …, 2·len. done is high in cycle 2·len+1 and busy is low from cycle 2·len+2.
  - Fill: mem_we is high in cycles 1..len, done is high in cycle len+1 and busy is low from cycle len+2.
  - len=0: done is high in cycle 1 and no write occurs.
- Each cycle with mem_re=0 in RD adds exactly one cycle of latency.
- Writes take effect at the rising edge that ends the WR or FILL cycle.
- A start held high across DONE into IDLE is accepted in the IDLE cycle, giving back-to-back commands with one idle cycle between them.

## Test plan
- Copy: memory model preloaded with 0x12, 0x34, 0x56, 0x78 at 0x80..0x83; src=0x80, dst=0x40, len=4, mode=0.
  - Required: mem[0x40..0x43]=12 34 56 78 and sum=0x14.
  - Required: done in cycle 9 and exactly 4 mem_we pulses.
- Fill with wrap: dst=0xFE, len=4, fill=0xA5.
  - Required: 0xFE, 0xFF, 0x00 and 0x01 all written to 0xA5; sum=0x94; done in cycle 5.
- Wait states: copy with len=2 while mem_re is held low for 3 cycles at the first read.
  - Required: done in cycle 8 and correct data at the destination.
- len=0 plus busy-start: start with len=0.
  - Required: done in cycle 1, no writes, sum=0x00.
  - Then: start pulses issued while busy are ignored, and sum is unchanged by them.
- Reset mid-copy: assert nRst low during the 3rd WR of an 8-byte copy.
  - Required: all outputs at their reset values, only 2 destination bytes written, and a new command after reset runs normally.
- Overlap: src=0x10, dst=0x11, len=3, with mem[0x10]=0xCC.
  - Required: mem[0x11..0x13]=CC CC CC.
